// File: rtl/fp_result_fifo.sv
// fp_result_fifo: result buffer behind the FP square-root pipeline.
//   The block captures each pipeline result into a FIFO. It also holds credits
//   for issue and keeps sticky IEEE exception flags.
// Latency: pipe_valid in cycle N gives result_valid in cycle N+1.
//   With FP_RESULT_FIFO_BYPASS_EN, an empty FIFO gives 0-cycle latency.
// Backpressure: result_ready stalls the head entry. Issue is throttled while
//   (count + inflight) reaches DEPTH, because the pipeline itself cannot stall.
// Ports:
//   clk, rst (async, active low)
//   issue_req/issue_ready : credit handshake toward the pipeline input
//   pipe_valid/data/flags : pipeline output strobe and payload
//   result_valid/ready/data/flags : consumer handshake
//   fflags, fflags_clr    : sticky flags {NV,OF,UF,NX} and their clear
//   drop_err              : sticky overflow/unsolicited-result error
// Optional feature macro: FP_RESULT_FIFO_BYPASS_EN (combinational empty-FIFO bypass).
module fp_result_fifo #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_req,
  output logic        issue_ready,
  input  logic        pipe_valid,
  input  logic [31:0] pipe_data,
  input  logic [3:0]  pipe_flags,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [31:0] result_data,
  output logic [3:0]  result_flags,
  output logic [3:0]  fflags,
  input  logic        fflags_clr,
  output logic        drop_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  // Entry layout: {flags[3:0], data[31:0]}
  logic [35:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [3:0]    fflags_q, fflags_d;
  logic          drop_err_q, drop_err_d;

  logic          fifo_empty, fifo_full;
  logic          issue_fire, fifo_deq, full_drop, wr_en, underflow;
  logic          bypass_act, bypass_take;
  logic [CW:0]   occupancy;
  logic [35:0]   head;

  assign head       = mem_q[rd_ptr_q];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(DEPTH));

  // Credits are registered-only, so the issue path never sees result_ready.
  assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
  assign issue_ready = (occupancy < (CW+1)'(DEPTH));
  assign issue_fire  = issue_req && issue_ready;

`ifdef FP_RESULT_FIFO_BYPASS_EN
  assign bypass_act  = fifo_empty && pipe_valid;
  assign bypass_take = bypass_act && result_ready;
`else
  assign bypass_act  = 1'b0;
  assign bypass_take = 1'b0;
`endif

  always_comb begin
    result_valid = !fifo_empty || bypass_act;
    result_data  = '0;
    result_flags = '0;
    if (bypass_act) begin
      result_data  = pipe_data;
      result_flags = pipe_flags;
    end else if (!fifo_empty) begin
      result_data  = head[31:0];
      result_flags = head[35:32];
    end
  end

  // A dequeue in the same cycle makes room, so a full FIFO still accepts then.
  assign fifo_deq  = !fifo_empty && result_ready;
  assign full_drop = pipe_valid && fifo_full && !fifo_deq;
  assign wr_en     = pipe_valid && !full_drop && !bypass_take;
  // A result with no credit outstanding was never issued by us.
  assign underflow = pipe_valid && !issue_fire && (inflight_q == '0);

  always_comb begin
    wr_ptr_d   = wr_en    ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = fifo_deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(wr_en) - CW'(fifo_deq);

    inflight_d = inflight_q;
    if (issue_fire && !pipe_valid)
      inflight_d = inflight_q + CW'(1);
    else if (pipe_valid && !issue_fire && inflight_q != '0)
      inflight_d = inflight_q - CW'(1);

    fflags_d   = (fflags_clr ? 4'b0 : fflags_q) |
                 ((pipe_valid && !full_drop) ? pipe_flags : 4'b0);
    drop_err_d = drop_err_q || full_drop || underflow;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      fflags_q   <= '0;
      drop_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      fflags_q   <= fflags_d;
      drop_err_q <= drop_err_d;
    end
  end

  // Storage is not reset; reads are masked by count until written.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {pipe_flags, pipe_data};
  end

  assign fflags   = fflags_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_fp_result_fifo.sv
// Bench for fp_result_fifo: the bench models the sqrt pipeline as an in-order
// queue with random latency. A scoreboard queue holds the expected results,
// and a negedge monitor pops the queue on each consumer handshake.
module tb_fp_result_fifo;
  localparam int DEPTH = 8;
`ifdef FP_RESULT_FIFO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 0, rst = 0;
  logic        issue_req = 0, issue_ready;
  logic        pipe_valid = 0;
  logic [31:0] pipe_data = 0;
  logic [3:0]  pipe_flags = 0;
  logic        result_valid, result_ready = 0;
  logic [31:0] result_data;
  logic [3:0]  result_flags, fflags;
  logic        fflags_clr = 0, drop_err;

  fp_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .issue_req(issue_req), .issue_ready(issue_ready),
    .pipe_valid(pipe_valid), .pipe_data(pipe_data), .pipe_flags(pipe_flags),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_data(result_data), .result_flags(result_flags),
    .fflags(fflags), .fflags_clr(fflags_clr), .drop_err(drop_err));

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] d;
    logic [3:0]  f;
  } pend_t;

  pend_t       pend[$];      // issued, not yet out of the pipeline
  logic [35:0] exp_q[$];     // expected FIFO contents, in order
  logic [3:0]  exp_ff = 0;
  logic        exp_drop = 0;
  int          n_chk = 0, n_pass = 0;
  int          cyc = 0, last_due = 0, n_issued = 0;
  logic        req_en = 0, rdy_en = 0, clr_req = 0, clr_on_del = 0, force_pv = 0;
  logic        fix_en = 0, delivered = 0;
  logic [31:0] fix_d = 0;
  logic [3:0]  fix_f = 0;
  logic [35:0] mon_e;

  function automatic void chk(string name, logic [35:0] act, logic [35:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Scoreboard monitor: compare the head on every consumer handshake.
  always @(negedge clk) begin
    if (rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_result: got %h expected none", {result_flags, result_data});
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {result_flags, result_data}, mon_e);
      end
    end
  end

  task automatic step();
    pend_t p;
    int    lat;
    @(posedge clk); #1; cyc++;
    // Credit rule: buffered plus outstanding operations must stay below DEPTH.
    chk("issue_ready", 36'(issue_ready), 36'((exp_q.size() + pend.size()) < DEPTH));
    chk("fflags", 36'(fflags), 36'(exp_ff));
    chk("drop_err", 36'(drop_err), 36'(exp_drop));
    pipe_valid = 0; pipe_data = 0; pipe_flags = 0;
    fflags_clr = clr_req; clr_req = 0;
    issue_req = req_en; result_ready = rdy_en; delivered = 0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      pipe_valid = 1; pipe_data = p.d; pipe_flags = p.f; delivered = 1;
      if (clr_on_del) begin fflags_clr = 1; clr_on_del = 0; end
      exp_q.push_back({p.f, p.d});
      exp_ff = (fflags_clr ? 4'b0 : exp_ff) | p.f;
    end else if (force_pv) begin
      // The FIFO is full and is not dequeuing, so the forced result must be dropped.
      pipe_valid = 1; pipe_data = 32'hDEADBEEF; pipe_flags = 4'hF;
      force_pv = 0; exp_drop = 1;
      if (fflags_clr) exp_ff = 0;
    end else if (fflags_clr) begin
      exp_ff = 0;
    end
    if (issue_req && issue_ready) begin
      lat = int'($urandom_range(2, 5));
      p.due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
      last_due = p.due;
      p.d = fix_en ? fix_d : $urandom;
      p.f = fix_en ? fix_f : 4'($urandom);
      pend.push_back(p);
      n_issued++;
    end
  endtask

  task automatic drain();
    req_en = 0; rdy_en = 1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (exp_q.size() == 0 && pend.size() == 0 && !result_valid) break;
    end
    chk("drain_done", 36'(exp_q.size() + pend.size()), 36'(0));
    chk("drain_valid", 36'(result_valid), 36'(0));
  endtask

  task automatic rand_phase(int n);
    for (int i = 0; i < n; i++) begin
      req_en = ($urandom_range(0, 9) < 7);
      rdy_en = ($urandom_range(0, 1) == 1);
      clr_req = ($urandom_range(0, 19) == 0);
      step();
    end
    drain();
  endtask

  initial begin
    // Reset values
    #2;
    chk("rst_valid", 36'(result_valid), 36'(0));
    chk("rst_data", 36'(result_data), 36'(0));
    chk("rst_flags", 36'(result_flags), 36'(0));
    chk("rst_fflags", 36'(fflags), 36'(0));
    chk("rst_drop", 36'(drop_err), 36'(0));
    chk("rst_ready", 36'(issue_ready), 36'(1));
    #10 rst = 1;

    // Single sqrt(4.0) result, latency check
    fix_en = 1; fix_d = 32'h40000000; fix_f = 4'b0;
    req_en = 1; rdy_en = 1; step(); req_en = 0;
    for (int i = 0; i < 20 && !delivered; i++) step();
    chk("t1_delivered", 36'(delivered), 36'(1));
    #1 chk("lat0_valid", 36'(result_valid), 36'(BYP));
    step();
    chk("lat1_valid", 36'(result_valid), 36'(!BYP));
    drain();
    chk("t1_fflags", 36'(fflags), 36'(0));

    // Backpressure fill: exactly DEPTH credits
    fix_en = 0; n_issued = 0; req_en = 1; rdy_en = 0;
    repeat (25) step();
    chk("fill_issues", 36'(n_issued), 36'(DEPTH));
    chk("fill_valid", 36'(result_valid), 36'(1));
    chk("fill_drop", 36'(drop_err), 36'(0));
    rdy_en = 1; repeat (6) step();
    drain();

    // Sticky flag accumulation
    clr_req = 1; step();
    fix_en = 1; fix_d = 32'h3F800000; fix_f = 4'b0001; req_en = 1; rdy_en = 1; step();
    fix_f = 4'b1000; step(); req_en = 0;
    drain();
    chk("fflags_1001", 36'(fflags), 36'(4'b1001));

    // Clear in the same cycle as an arriving flag
    fix_f = 4'b0100; clr_on_del = 1; req_en = 1; step(); req_en = 0;
    drain();
    chk("fflags_clr_same", 36'(fflags), 36'(4'b0100));
    fix_en = 0;

    rand_phase(300);

    // Forced arrival into a full, stalled FIFO
    req_en = 1; rdy_en = 0; repeat (20) step();
    req_en = 0; repeat (8) step();
    force_pv = 1; step(); step();
    chk("drop_set", 36'(drop_err), 36'(1));
    drain();
    chk("drop_sticky", 36'(drop_err), 36'(1));

    // Async reset mid-burst with 3 entries buffered
    req_en = 1; rdy_en = 0; repeat (3) step();
    req_en = 0; repeat (8) step();
    chk("pre_rst_valid", 36'(result_valid), 36'(1));
    @(posedge clk); #3 rst = 0; #1;
    chk("arst_valid", 36'(result_valid), 36'(0));
    chk("arst_data", 36'(result_data), 36'(0));
    chk("arst_flags", 36'(result_flags), 36'(0));
    chk("arst_fflags", 36'(fflags), 36'(0));
    chk("arst_drop", 36'(drop_err), 36'(0));
    chk("arst_ready", 36'(issue_ready), 36'(1));
    exp_q.delete(); pend.delete(); exp_ff = 0; exp_drop = 0;
    issue_req = 0; pipe_valid = 0; result_ready = 0; fflags_clr = 0;
    repeat (2) @(posedge clk);
    #2 rst = 1;
    last_due = cyc;
    step();
    chk("post_rst_ready", 36'(issue_ready), 36'(1));
    rand_phase(150);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fp_result_fifo.md
# fp_result_fifo

Downstream consumer of the floating-point square-root pipeline. Captures each `out`/flag bundle on the pipeline's `valid_data_out` strobe, buffers it in a FIFO and presents it to the next stage over a ready/valid handshake. The pipeline has no stall input, so this block also runs a credit counter that throttles issue to the pipeline, guaranteeing no result is ever dropped. It also keeps sticky IEEE-754 exception flags.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2; also the credit limit.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `issue_req` input 1: upstream wants to issue an operand to the pipeline this cycle.
- `issue_ready` output 1: a credit is available; issue happens when `issue_req && issue_ready`. The upstream drives the pipeline `valid_data_in` with exactly this AND.
- `pipe_valid` input 1: pipeline `valid_data_out`.
- `pipe_data` input 32: pipeline `out`.
- `pipe_flags` input 4: {invalid_operation, overflow, underflow, inexact} from the pipeline.
- `result_valid` output 1: head entry valid.
- `result_ready` input 1: consumer accepts the head.
- `result_data` output 32: head result.
- `result_flags` output 4: head flags, same order as `pipe_flags`.
- `fflags` output 4: sticky OR of the flags of every enqueued result.
- `fflags_clr` input 1: clears `fflags`.
- `drop_err` output 1: sticky error, set if `pipe_valid` arrives with the FIFO full.

## Operation
- Storage: DEPTH×36-bit array. Write pointer and read pointer are log2(DEPTH) bits and wrap naturally. Occupancy `count` is log2(DEPTH+1) bits.
- In-flight counter `inflight` (log2(DEPTH+1) bits):
  - +1 on issue.
  - −1 on `pipe_valid`.
  - Unchanged when both happen in the same cycle.
- `issue_ready = (count + inflight) < DEPTH`, combinational from registers only. It does not depend on `result_ready` in the same cycle.
- Enqueue on `pipe_valid`. Dequeue on `result_valid && result_ready`.
  - Simultaneous enqueue and dequeue: `count` is unchanged and both pointers advance.
- Full with `pipe_valid` and no dequeue in the same cycle: the write is discarded and `drop_err` is set. `drop_err` clears only on reset. It is unreachable if the credit rule is obeyed.
- `result_data`/`result_flags` show the head entry and hold stable while `result_valid && !result_ready`.
- `fflags` update: `fflags <= (fflags_clr ? 0 : fflags) | (pipe_valid ? pipe_flags : 0)`. A flag arriving in the clear cycle survives.
  - A dropped result does not update `fflags`.
- `inflight` underflow (`pipe_valid` with `inflight==0` and no issue) saturates at 0 and sets `drop_err`.

## Timing
- Reset (`rst` low, async) values:
  - `result_valid`=0, `result_data`=0, `result_flags`=0.
  - `fflags`=0, `drop_err`=0.
  - `issue_ready`=1; `count`, `inflight` and pointers = 0.
- Reset mid-operation discards all buffered and in-flight bookkeeping. Results arriving from the pipeline after reset release are treated as unsolicited: they are enqueued and `drop_err` is set, per the underflow rule.
- Latency: `pipe_valid` in cycle N → `result_valid` in cycle N+1 (non-bypass build).
- Credits:
  - A dequeue in cycle N frees a credit visible in cycle N+1.
  - A result arrival never frees a credit by itself; the credit only moves from `inflight` to `count`.
- Full throughput: one enqueue and one dequeue per cycle in steady state.

## Configuration
- `FP_RESULT_FIFO_BYPASS_EN` defined, when the FIFO is empty and `pipe_valid` is high:
  - `result_valid`/`result_data`/`result_flags` are driven combinationally from the `pipe_*` inputs in the same cycle.
  - If `result_ready` is high, nothing is written, `count` stays 0 and latency is 0 cycles.
  - If `result_ready` is low, the entry is written normally.
  - `fflags` updates identically in both cases.
- Macro undefined: no combinational path from `pipe_*` to `result_*`; latency is always 1 cycle.

## Test plan
- Reset, then issue one operand whose pipeline result is `pipe_data`=0x40000000 (sqrt 4.0), `pipe_flags`=0, with `result_ready`=1 → `result_data`=0x40000000 one cycle after `pipe_valid` (same cycle with BYPASS), `fflags`=0.
- Hold `result_ready`=0 with `issue_req`=1 continuously, DEPTH=8 → exactly 8 issues accepted, `issue_ready` stays 0 after them, 8 results buffered in order, `drop_err`=0.
- Then raise `result_ready`=1 → results drain in order. The first freed credit is visible the cycle after the first dequeue.
- Results with flags 4'b0001 then 4'b1000 → `fflags`=4'b1001.
- Assert `fflags_clr` in the same cycle as a `pipe_valid` carrying 4'b0100 → `fflags`=4'b0100.
- Force `pipe_valid` while the FIFO is full and not dequeuing → entry discarded, `drop_err`=1, sticky until reset.
- Pulse `rst` low asynchronously mid-burst with 3 entries buffered → all outputs return to reset values immediately, and `issue_ready`=1 after release.
